// File: rtl/icap_ctrl_pkg.sv
// icap_ctrl_pkg -- shared definitions for the ICAPE2 (X32) controller.
//   Configuration word constants, Type-1 register addresses, the
//   sequencer state type and the read-header builder.
package icap_ctrl_pkg;

  localparam logic [31:0] W_DUMMY      = 32'hFFFF_FFFF;
  localparam logic [31:0] W_SYNC       = 32'hAA99_5566;
  localparam logic [31:0] W_NOOP       = 32'h2000_0000;
  localparam logic [31:0] W_WBSTAR_HDR = 32'h3002_0001;
  localparam logic [31:0] W_CMD_HDR    = 32'h3000_8001;
  localparam logic [31:0] W_IPROG      = 32'h0000_000F;
  localparam logic [31:0] W_DESYNC     = 32'h0000_000D;

  localparam logic [4:0] REG_STAT    = 5'h07;
  localparam logic [4:0] REG_IDCODE  = 5'h0C;
  localparam logic [4:0] REG_BOOTSTS = 5'h16;
  localparam logic [4:0] REG_WBSTAR  = 5'h10;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_DUMMY,
    ST_SYNC,
    ST_NOOP,
    ST_HDR,
    ST_ARG,
    ST_CMD,
    ST_IPROG,
    ST_FIN_NOOP,
    ST_TURN,
    ST_WAIT,
    ST_CAP,
    ST_BACK,
    ST_DS_CMD,
    ST_DS_DESYNC,
    ST_DS_NOOP,
    ST_DONE
  } icap_state_e;

  // Type-1 read header, word count 1, for the given register address.
  function automatic logic [31:0] rd_hdr(input logic [4:0] reg_addr);
    return 32'h2800_0001 | ({27'd0, reg_addr} << 13);
  endfunction

endpackage

// File: rtl/icap_ctrl_if.sv
// icap_ctrl_if -- request/response bus of icap_ctrl.
//   REBOOT_REQ/REBOOT_ADDR : warm-reboot request and WBSTAR value
//   RD_REQ/RD_REG          : configuration-register read request
//   RD_DATA/RD_VALID       : read result and its one-cycle strobe
//   BUSY/REQ_DROP          : sequencer busy, rejected-request pulse
//   master = requester side, slave = icap_ctrl side.
interface icap_ctrl_if;

  logic        REBOOT_REQ;
  logic [31:0] REBOOT_ADDR;
  logic        RD_REQ;
  logic [4:0]  RD_REG;
  logic [31:0] RD_DATA;
  logic        RD_VALID;
  logic        BUSY;
  logic        REQ_DROP;

  modport master (
    output REBOOT_REQ, REBOOT_ADDR, RD_REQ, RD_REG,
    input  RD_DATA, RD_VALID, BUSY, REQ_DROP
  );

  modport slave (
    input  REBOOT_REQ, REBOOT_ADDR, RD_REQ, RD_REG,
    output RD_DATA, RD_VALID, BUSY, REQ_DROP
  );

endinterface

// File: rtl/icap_bitswap.sv
// icap_bitswap -- combinational ICAP data-path bit ordering.
//   i_data : 32-bit word in
//   o_data : 32-bit word out
// With ICAP_CTRL_BITSWAP_EN defined, bits are reversed inside each byte
// (byte positions kept), as 7-series ICAPE2 expects. Undefined, the word
// passes straight through. The mapping is its own inverse, so the same
// block serves both the write and the read direction.
module icap_bitswap (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

`ifdef ICAP_CTRL_BITSWAP_EN
  always_comb begin
    o_data = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      for (int unsigned k = 0; k < 8; k++) begin
        o_data[8*b + k] = i_data[8*b + 7 - k];
      end
    end
  end
`else
  assign o_data = i_data;
`endif

endmodule

// File: rtl/icap_ctrl.sv
// icap_ctrl -- ICAPE2 (X32) sequencer for warm reboot (IPROG) and
// configuration-register reads.
//   CLK, RST    : single clock, synchronous active-high reset
//   bus         : icap_ctrl_if.slave request/response bus
//   ICAP_CSIB   : ICAPE2 chip select (active low)
//   ICAP_RDWRB  : ICAPE2 direction (1 = read)
//   ICAP_I      : word to ICAPE2
//   ICAP_O      : word from ICAPE2
// Parameter READ_LAT (1..15): cycles between CSIB low in read mode and
// the ICAP_O capture.
// Macro ICAP_CTRL_BITSWAP_EN: byte-wise bit reversal on ICAP_I/ICAP_O.
module icap_ctrl
  import icap_ctrl_pkg::*;
#(
  parameter int unsigned READ_LAT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  icap_ctrl_if.slave  bus,
  output logic        ICAP_CSIB,
  output logic        ICAP_RDWRB,
  output logic [31:0] ICAP_I,
  input  logic [31:0] ICAP_O
);

  localparam logic [3:0] LAT4 = 4'(READ_LAT);

  icap_state_e r_state;
  icap_state_e w_next;

  logic        r_is_read;
  logic [31:0] r_addr;
  logic [4:0]  r_reg;
  logic [3:0]  r_cnt;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;
  logic        r_drop;

  logic        w_any_req;
  logic        w_accept;
  logic        w_drop;
  logic        w_csib;
  logic        w_rdwrb;
  logic [31:0] w_word;
  logic [31:0] w_cap_data;

  assign w_any_req = bus.REBOOT_REQ | bus.RD_REQ;
  assign w_accept  = (r_state == ST_IDLE) && w_any_req;
  // Busy drops the request outright; in IDLE a simultaneous pair loses
  // the read because the reboot takes priority.
  assign w_drop    = (r_state != ST_IDLE) ? w_any_req
                                          : (bus.REBOOT_REQ & bus.RD_REQ);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_csib  = 1'b1;
    w_rdwrb = 1'b0;
    w_word  = W_DUMMY;
    unique case (r_state)
      ST_IDLE:      if (w_any_req) w_next = ST_DUMMY;
      ST_DUMMY:     begin w_csib = 1'b0; w_word = W_DUMMY; w_next = ST_SYNC; end
      ST_SYNC:      begin w_csib = 1'b0; w_word = W_SYNC;  w_next = ST_NOOP; end
      ST_NOOP:      begin w_csib = 1'b0; w_word = W_NOOP;  w_next = ST_HDR;  end
      ST_HDR: begin
        w_csib = 1'b0;
        w_word = r_is_read ? rd_hdr(r_reg) : W_WBSTAR_HDR;
        w_next = ST_ARG;
      end
      ST_ARG: begin
        w_csib = 1'b0;
        w_word = r_is_read ? W_NOOP : r_addr;
        w_next = ST_CMD;
      end
      ST_CMD: begin
        w_csib = 1'b0;
        w_word = r_is_read ? W_NOOP : W_CMD_HDR;
        w_next = r_is_read ? ST_TURN : ST_IPROG;
      end
      ST_IPROG:     begin w_csib = 1'b0; w_word = W_IPROG; w_next = ST_FIN_NOOP; end
      ST_FIN_NOOP:  begin w_csib = 1'b0; w_word = W_NOOP;  w_next = ST_DONE;     end
      // Direction flips only in deselected cycles (TURN, BACK).
      ST_TURN:      begin w_rdwrb = 1'b1; w_next = ST_WAIT; end
      ST_WAIT: begin
        w_csib  = 1'b0;
        w_rdwrb = 1'b1;
        if (r_cnt <= 4'd1) w_next = ST_CAP;
      end
      ST_CAP:       begin w_csib = 1'b0; w_rdwrb = 1'b1; w_next = ST_BACK; end
      ST_BACK:      w_next = ST_DS_CMD;
      ST_DS_CMD:    begin w_csib = 1'b0; w_word = W_CMD_HDR; w_next = ST_DS_DESYNC; end
      ST_DS_DESYNC: begin w_csib = 1'b0; w_word = W_DESYNC;  w_next = ST_DS_NOOP;   end
      ST_DS_NOOP:   begin w_csib = 1'b0; w_word = W_NOOP;    w_next = ST_DONE;      end
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_is_read  <= 1'b0;
      r_addr     <= '0;
      r_reg      <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_read <= ~bus.REBOOT_REQ;
        r_addr    <= bus.REBOOT_ADDR;
        r_reg     <= bus.RD_REG;
      end
      // Reload on TURN, count down in WAIT, saturate at zero.
      if (r_state == ST_TURN)
        r_cnt <= LAT4;
      else if (r_state == ST_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (r_state == ST_CAP)
        r_rd_data <= w_cap_data;
      r_rd_valid <= (r_state == ST_CAP);
      r_drop     <= w_drop;
    end
  end

  icap_bitswap u_swap_i (
    .i_data (w_word),
    .o_data (ICAP_I)
  );

  icap_bitswap u_swap_o (
    .i_data (ICAP_O),
    .o_data (w_cap_data)
  );

  assign ICAP_CSIB    = w_csib;
  assign ICAP_RDWRB   = w_rdwrb;
  assign bus.RD_DATA  = r_rd_data;
  assign bus.RD_VALID = r_rd_valid;
  assign bus.BUSY     = (r_state != ST_IDLE);
  assign bus.REQ_DROP = r_drop;

endmodule

// File: tb/tb_icap_ctrl.sv
// tb_icap_ctrl -- randomized self-checking bench for icap_ctrl with a
// behavioural ICAPE2 register model. Expected per-cycle bus activity is
// built from the command word lists of each transaction type.
module tb_icap_ctrl;

  localparam int unsigned LAT = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ICAP_CSIB;
  logic        ICAP_RDWRB;
  logic [31:0] ICAP_I;
  logic [31:0] ICAP_O = '0;

  icap_ctrl_if bus ();

  icap_ctrl #(.READ_LAT(LAT)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .ICAP_CSIB  (ICAP_CSIB),
    .ICAP_RDWRB (ICAP_RDWRB),
    .ICAP_I     (ICAP_I),
    .ICAP_O     (ICAP_O)
  );

  always #5 CLK = ~CLK;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] swz(input logic [31:0] w);
`ifdef ICAP_CTRL_BITSWAP_EN
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[(i / 8) * 8 + 7 - (i % 8)];
    return r;
`else
    return w;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- ICAPE2 model ----------------
  logic [31:0] regs [32];
  logic [4:0]  hreg = '0;
  int unsigned rcnt = 0;

  always @(negedge CLK) begin
    logic [31:0] w;
    w = swz(ICAP_I);
    if (ICAP_CSIB) rcnt = 0;
    else if (ICAP_RDWRB) rcnt++;
    else if (w[31:18] == 14'h0A00 && w[12:0] == 13'h1) hreg = w[17:13];
    // Data is only valid in the cycle after READ_LAT selected read cycles.
    if (!ICAP_CSIB && ICAP_RDWRB && rcnt == LAT + 1) ICAP_O = swz(regs[hreg]);
    else ICAP_O = $urandom;
  end

  // ---------------- protocol assertions ----------------
  a_rdwrb: assert property (@(posedge CLK) disable iff (RST)
      $changed(ICAP_RDWRB) |-> ICAP_CSIB)
    else begin
      n_err++;
      $display("FAIL assert_rdwrb: RDWRB changed with CSIB=%b, required 1", ICAP_CSIB);
    end

  a_nodrop: assert property (@(posedge CLK) disable iff (RST)
      (!bus.BUSY && (bus.REBOOT_REQ ^ bus.RD_REQ)) |=> !bus.REQ_DROP)
    else begin
      n_err++;
      $display("FAIL assert_nodrop: REQ_DROP=%b after acceptance, required 0", bus.REQ_DROP);
    end

  // ---------------- expected sequence ----------------
  typedef struct {
    bit          csib;
    bit          rdwrb;
    bit          has_w;
    logic [31:0] w;
    bit          cap;
  } step_t;

  step_t       steps[$];
  logic [31:0] last_rd = '0;

  function automatic void add(input bit c, input bit r, input bit h, input logic [31:0] w, input bit cap);
    step_t s;
    s.csib = c; s.rdwrb = r; s.has_w = h; s.w = w; s.cap = cap;
    steps.push_back(s);
  endfunction

  function automatic void build(input bit rd, input logic [31:0] addr, input logic [4:0] rg);
    steps.delete();
    add(0, 0, 1, 32'hFFFF_FFFF, 0);
    add(0, 0, 1, 32'hAA99_5566, 0);
    add(0, 0, 1, 32'h2000_0000, 0);
    if (!rd) begin
      add(0, 0, 1, 32'h3002_0001, 0);
      add(0, 0, 1, addr, 0);
      add(0, 0, 1, 32'h3000_8001, 0);
      add(0, 0, 1, 32'h0000_000F, 0);
      add(0, 0, 1, 32'h2000_0000, 0);
    end else begin
      add(0, 0, 1, 32'h2800_0001 + {27'd0, rg} * 32'h2000, 0);
      add(0, 0, 1, 32'h2000_0000, 0);
      add(0, 0, 1, 32'h2000_0000, 0);
      add(1, 1, 0, '0, 0);
      for (int i = 0; i < int'(LAT); i++) add(0, 1, 0, '0, 0);
      add(0, 1, 0, '0, 1);
      add(1, 0, 0, '0, 0);
      add(0, 0, 1, 32'h3000_8001, 0);
      add(0, 0, 1, 32'h0000_000D, 0);
      add(0, 0, 1, 32'h2000_0000, 0);
    end
    add(1, 0, 0, '0, 0);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(bus.BUSY), 0);
    chk({tag, "_csib"},  32'(ICAP_CSIB), 1);
    chk({tag, "_rdwrb"}, 32'(ICAP_RDWRB), 0);
    chk({tag, "_icapi"}, ICAP_I, swz(32'hFFFF_FFFF));
    chk({tag, "_valid"}, 32'(bus.RD_VALID), 0);
    chk({tag, "_rddata"}, bus.RD_DATA, last_rd);
  endtask

  // inj: 0 none, 1 RD_REQ mid-run, 2 random request type mid-run
  task automatic run_txn(input bit reb, input bit rd, input logic [31:0] addr,
                         input logic [4:0] rg, input logic [31:0] rv, input int inj);
    bit is_rd;
    bit drop_next;
    int inj_at;
    is_rd = rd && !reb;
    if (is_rd) regs[rg] = rv;
    build(is_rd, addr, rg);
    inj_at = (inj != 0) ? int'($urandom_range(1, steps.size() - 2)) : -1;
    bus.REBOOT_REQ  = reb;
    bus.RD_REQ      = rd;
    bus.REBOOT_ADDR = addr;
    bus.RD_REG      = rg;
    tick();
    bus.REBOOT_REQ  = 1'b0;
    bus.RD_REQ      = 1'b0;
    bus.REBOOT_ADDR = $urandom;
    bus.RD_REG      = 5'($urandom);
    drop_next = reb && rd;
    for (int i = 0; i < steps.size(); i++) begin
      bit exp_v;
      exp_v = (i > 0) && steps[i-1].cap;
      chk("csib",  32'(ICAP_CSIB), 32'(steps[i].csib));
      chk("rdwrb", 32'(ICAP_RDWRB), 32'(steps[i].rdwrb));
      if (steps[i].has_w) chk("icap_i", ICAP_I, swz(steps[i].w));
      chk("busy",     32'(bus.BUSY), 1);
      chk("req_drop", 32'(bus.REQ_DROP), 32'(drop_next));
      chk("rd_valid", 32'(bus.RD_VALID), 32'(exp_v));
      if (exp_v) begin
        chk("rd_data", bus.RD_DATA, rv);
        // Request launched after edge E; RD_VALID must rise after edge E+12.
        chk("rd_latency", i + 1, 12);
        last_rd = rv;
      end
      drop_next = (i == inj_at);
      if (i == inj_at) begin
        if (inj == 1 || $urandom_range(1) == 1) bus.RD_REQ = 1'b1;
        else bus.REBOOT_REQ = 1'b1;
        bus.RD_REG      = 5'($urandom);
        bus.REBOOT_ADDR = $urandom;
      end
      tick();
      bus.RD_REQ     = 1'b0;
      bus.REBOOT_REQ = 1'b0;
    end
    chk("end_drop", 32'(bus.REQ_DROP), 0);
    chk_idle("end");
  endtask

  task automatic reset_in_wait();
    logic [4:0] rg;
    rg = 5'h16;
    regs[rg] = 32'h1234_5678;
    bus.RD_REQ = 1'b1;
    bus.RD_REG = rg;
    tick();
    bus.RD_REQ = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("rw_wait_csib",  32'(ICAP_CSIB), 0);
    chk("rw_wait_rdwrb", 32'(ICAP_RDWRB), 1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    last_rd = '0;
    chk("rw_drop", 32'(bus.REQ_DROP), 0);
    chk_idle("rw_idle");
    for (int i = 0; i < int'(LAT) + 8; i++) begin
      tick();
      chk("rw_after_valid", 32'(bus.RD_VALID), 0);
      chk("rw_after_csib",  32'(ICAP_CSIB), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    bus.REBOOT_REQ  = 1'b0;
    bus.RD_REQ      = 1'b0;
    bus.REBOOT_ADDR = '0;
    bus.RD_REG      = '0;
    tick();
    tick();
    chk("rst_csib",   32'(ICAP_CSIB), 1);
    chk("rst_rdwrb",  32'(ICAP_RDWRB), 0);
    chk("rst_busy",   32'(bus.BUSY), 0);
    chk("rst_valid",  32'(bus.RD_VALID), 0);
    chk("rst_drop",   32'(bus.REQ_DROP), 0);
    chk("rst_rddata", bus.RD_DATA, 0);
    RST = 1'b0;
    tick();
    chk_idle("post_rst");

    run_txn(0, 1, 32'h0, 5'h0C, 32'h0365_1093, 0);       // IDCODE read
    run_txn(1, 0, 32'h0040_0000, 5'h0, 32'h0, 0);        // warm reboot
    run_txn(1, 1, 32'h0080_0000, 5'h07, 32'h0, 0);       // simultaneous
    run_txn(0, 1, 32'h0, 5'h16, 32'hCAFE_0016, 1);       // read + mid-run RD_REQ
    reset_in_wait();
    tick();

    for (int n = 0; n < 24; n++) begin
      int unsigned kind;
      logic [4:0] rg;
      kind = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
        0: rg = 5'h07;
        1: rg = 5'h0C;
        2: rg = 5'h16;
        3: rg = 5'h10;
        default: rg = 5'($urandom);
      endcase
      case (kind)
        0: run_txn(1, 0, $urandom, rg, 32'h0, int'($urandom_range(0, 2)));
        1, 3: run_txn(0, 1, $urandom, rg, $urandom, int'($urandom_range(0, 2)));
        default: run_txn(1, 1, $urandom, rg, 32'h0, int'($urandom_range(0, 2)));
      endcase
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick();
        chk_idle("gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/icap_ctrl.md
ICAP_CTRL -- requirements
Module: icap_ctrl

Interface
REQ-001 SHALL have parameter READ_LAT, default 3, meaning cycles between CSIB low in read mode and the ICAP_O capture (1..15).
REQ-002 SHALL have port CLK  input  1  single clock for all logic and for the ICAPE2 CLK.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port REBOOT_REQ  input  1  one-cycle pulse requesting a warm reboot (IPROG).
REQ-005 SHALL have port REBOOT_ADDR  input  32  WBSTAR value, sampled with REBOOT_REQ.
REQ-006 SHALL have port RD_REQ  input  1  one-cycle pulse requesting a configuration-register read.
REQ-007 SHALL have port RD_REG  input  5  Type-1 register address, sampled with RD_REQ.
REQ-008 SHALL have port RD_DATA  output  32  read result, held until the next capture.
REQ-009 SHALL have port RD_VALID  output  1  one-cycle pulse when RD_DATA updates.
REQ-010 SHALL have port BUSY  output  1  high from the cycle after acceptance until the return to IDLE.
REQ-011 SHALL have port REQ_DROP  output  1  one-cycle pulse when a request is not accepted.
REQ-012 SHALL have ports ICAP_CSIB (output, 1), ICAP_RDWRB (output, 1), ICAP_I (output, 32) and ICAP_O (input, 32), which connect directly to ICAPE2 (X32).

Function
REQ-013 SHALL accept a request only in IDLE; a request while BUSY SHALL be ignored and SHALL pulse REQ_DROP the next cycle.
REQ-014 SHALL give REBOOT_REQ priority when both requests arrive in the same cycle: the reboot is accepted and REQ_DROP pulses for the read.
REQ-015 SHALL latch REBOOT_ADDR or RD_REG on acceptance; later input changes SHALL have no effect.
REQ-016 SHALL drive one word per cycle with CSIB=0 and RDWRB=0 in the write states: DUMMY FFFFFFFF, SYNC AA995566, NOOP 20000000, HDR, ARG, CMD.
REQ-017 On the reboot path: HDR=30020001, ARG=latched address, CMD=30008001, then IPROG=0000000F, one FIN_NOOP=20000000, then DONE.
REQ-018 On the read path: HDR=28000001|(RD_REG<<13), ARG=NOOP, CMD=NOOP.
REQ-019 After CMD on the read path, the sequence SHALL be: TURN (CSIB=1, RDWRB=1), then WAIT (CSIB=0, RDWRB=1) for READ_LAT cycles, then CAP.
REQ-020 In CAP, RD_DATA SHALL be loaded from ICAP_O and RD_VALID SHALL pulse once.
REQ-021 After CAP: BACK (CSIB=1, RDWRB=0), then DS_CMD=30008001, DS_DESYNC=0000000D, DS_NOOP=20000000, then DONE.
REQ-022 RDWRB SHALL change only in cycles where CSIB=1.
REQ-023 DONE SHALL drive CSIB=1 and go to IDLE in the next cycle; BUSY SHALL drop when IDLE is entered.
REQ-024 In IDLE, outputs SHALL be CSIB=1, RDWRB=0 and ICAP_I=bitswap(FFFFFFFF).
REQ-025 Bit order: ICAP_I and the captured ICAP_O SHALL be bit-reversed within each byte, bytes kept in place (see REQ-030).
REQ-026 The wait counter SHALL be 4 bits, reload on TURN and never wrap.
REQ-027 Latency: a read with READ_LAT=3 SHALL pulse RD_VALID 12 cycles after the RD_REQ edge.

Reset
REQ-028 RST SHALL, at any state including mid-sequence, force IDLE on the next edge.
REQ-029 On reset the outputs SHALL be: CSIB=1, RDWRB=0, BUSY=0, RD_VALID=0, REQ_DROP=0, RD_DATA=00000000, counter=0. No partial desync SHALL be issued.

Configuration
REQ-030 Macro ICAP_CTRL_BITSWAP_EN defined: the byte-wise bit reversal SHALL be applied to ICAP_I and ICAP_O. Undefined: both pass straight through, for non-7-series or external-swap use.

Structure
REQ-031 Package icap_ctrl_pkg SHALL hold the word constants (DUMMY, SYNC, NOOP, WBSTAR_HDR, CMD_HDR, IPROG, DESYNC), the register constants (STAT=07, IDCODE=0C, BOOTSTS=16, WBSTAR=10), the state enum and a read-header function.
REQ-032 Sub-module icap_bitswap (32-bit, combinational) SHALL be instantiated twice, once for I and once for O; ICAPE2 SHALL be instantiated outside icap_ctrl.

Verification
REQ-033 RD_REQ with RD_REG=0C and ICAP model IDCODE 03651093 -> header 28018001 is written, RD_DATA=03651093, RD_VALID pulses once, desync sequence follows, BUSY falls.
REQ-034 REBOOT_REQ with ADDR=00400000 -> word order FFFFFFFF, AA995566, 20000000, 30020001, 00400000, 30008001, 0000000F, 20000000 (pre-swap), CSIB=0 throughout.
REQ-035 REBOOT_REQ and RD_REQ in the same cycle -> reboot sequence runs, REQ_DROP pulses one cycle, no RD_VALID.
REQ-036 RD_REQ during a running read -> REQ_DROP pulses and RD_REG is unchanged for the running read.
REQ-037 RST asserted in WAIT -> next cycle IDLE, CSIB=1, RDWRB=0, BUSY=0, no RD_VALID.
REQ-038 Assertion checks over all scenarios, with and without ICAP_CTRL_BITSWAP_EN: RDWRB never toggles while CSIB=0, and REQ_DROP never coincides with acceptance.
